// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer between redirect logic, I-cache and re-aligner
module fetch_sequencer #(
    parameter int FETCH_WIDTH     = 64,
    parameter int MAX_OUTSTANDING = 2,
    parameter int IQ_CREDITS      = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [63:0]            boot_addr_i,
    input  logic                   flush_i,
    input  logic                   redirect_valid_i,
    input  logic [63:0]            redirect_pc_i,
    input  logic                   halt_i,
    output logic                   halted_o,
    output logic                   req_valid_o,
    input  logic                   req_ready_i,
    output logic [63:0]            req_vaddr_o,
    input  logic                   resp_valid_i,
    input  logic [FETCH_WIDTH-1:0] resp_data_i,
    output logic                   realign_valid_o,
    output logic                   realign_en_o,
    output logic                   realign_flush_o,
    output logic [63:0]            realign_addr_o,
    output logic [FETCH_WIDTH-1:0] realign_data_o,
    input  logic                   iq_pop_i
);

    localparam int GROUP_B = FETCH_WIDTH / 8;
    localparam int OUT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam int CRD_W   = $clog2(IQ_CREDITS) + 1;
    localparam int PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [OUT_W-1:0] OUT_MAX     = OUT_W'(MAX_OUTSTANDING);
    localparam logic [CRD_W-1:0] CRD_MAX     = CRD_W'(IQ_CREDITS);
    localparam logic [63:0]      ALIGN_MASK  = ~64'(GROUP_B - 1);
    localparam logic [63:0]      GROUP_BYTES = 64'(GROUP_B);

    typedef enum logic [2:0] {
        BOOT,
        FETCH,
        DRAIN,
        HALTED,
        STOPPED
    } state_t;

    state_t           state;
    logic [63:0]      pc;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] kill_cnt;
    logic [OUT_W-1:0] outstanding_next;
    logic [CRD_W-1:0] credits;
    logic [63:0]      addr_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             handshake;
    logic             killed;
    logic             redirect_or_flush;

    assign redirect_or_flush = redirect_valid_i || flush_i;

    assign req_valid_o = (state == FETCH) && (credits != '0) && (outstanding < OUT_MAX)
                         && !redirect_or_flush && !halt_i;
    assign handshake   = req_valid_o && req_ready_i;
    assign req_vaddr_o = pc;

    // A response is forwarded only when nothing older is still marked for killing
    // and no redirect/flush is happening in the same cycle.
    assign realign_valid_o = resp_valid_i && (kill_cnt == '0) && !redirect_or_flush;
    assign realign_en_o    = realign_valid_o;
    assign realign_flush_o = redirect_or_flush;
    assign realign_addr_o  = addr_fifo[rd_ptr];
    assign realign_data_o  = resp_data_i;
    assign killed          = resp_valid_i && !realign_valid_o;
    assign halted_o        = (state == HALTED);

    assign outstanding_next = outstanding + OUT_W'(handshake) - OUT_W'(resp_valid_i);

    // Fetch PC and control state; redirects take priority over PC advance and halt
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= BOOT;
            pc    <= '0;
        end else if (state == BOOT) begin
            pc    <= boot_addr_i;
            state <= FETCH;
        end else begin
            if (redirect_valid_i) begin
                pc <= redirect_pc_i;
            end else if (handshake) begin
                pc <= (pc & ALIGN_MASK) + GROUP_BYTES;
            end
            if (flush_i && !redirect_valid_i) begin
                state <= STOPPED;
            end else begin
                case (state)
                    FETCH:   if (!redirect_valid_i && halt_i) state <= DRAIN;
                    DRAIN:   if (outstanding == '0) state <= HALTED;
                    HALTED:  if (!halt_i) state <= FETCH;
                    STOPPED: if (redirect_valid_i) state <= FETCH;
                    default: state <= state;
                endcase
            end
        end
    end

    // Outstanding/credit/kill bookkeeping and the in-flight address FIFO
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding <= '0;
            kill_cnt    <= '0;
            credits     <= CRD_MAX;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                addr_fifo[i] <= '0;
            end
        end else begin
            outstanding <= outstanding_next;
            credits     <= credits + CRD_W'(iq_pop_i) + CRD_W'(killed) - CRD_W'(handshake);
            if (redirect_or_flush) begin
                kill_cnt <= outstanding_next;
            end else if (resp_valid_i && (kill_cnt != '0)) begin
                kill_cnt <= kill_cnt - OUT_W'(1);
            end
            if (handshake) begin
                addr_fifo[wr_ptr] <= pc;
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (resp_valid_i) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
        end
    end

    // Interface protocol checks: no stray responses, no credit overflow, no issue outside FETCH
    assert property (@(posedge clk_i) disable iff (!rst_ni) resp_valid_i |-> (outstanding != '0));
    assert property (@(posedge clk_i) disable iff (!rst_ni) credits <= CRD_MAX);
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     handshake |-> ((state == FETCH) && (outstanding < OUT_MAX)));

endmodule
